// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the datapath, the memory arbiter and the RAM port.
// slave is the arbiter's view; master is the combined datapath + RAM view.
interface mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        ihit;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dhit;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ramready;
   logic        err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
      output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
      input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one RAM port, data first,
// with a fairness flag against fetch starvation and a watchdog on RAM stalls.
module mem_arbiter #(
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
   input logic          CLK,
   input logic          nRST,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

   localparam int unsigned    CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

   state_t        state, next_state;
   logic [CW-1:0] wait_cnt;
   logic          last_d;
   logic          wd;
   logic          pick_d, pick_i;
   logic          timeout, done, abort;

   always_comb begin
      pick_d     = (bus.dREN || bus.dWEN) && !(bus.iREN && last_d);
      pick_i     = !pick_d && bus.iREN;
      timeout    = !bus.ramready && (wait_cnt == CNT_MAX);
      done       = bus.ramready || timeout;
      // withdrawal is sticky across the access, including its completion cycle
      abort      = wd || ((state == DACC) ? !(bus.dREN || bus.dWEN) : !bus.iREN);
      next_state = state;
      case (state)
         IDLE, RESP: next_state = pick_d ? DACC : (pick_i ? IACC : IDLE);
         IACC, DACC: if (done) next_state = RESP;
         default:    next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   // RAM strobes/address double as the latched request for the whole access
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wait_cnt     <= '0;
         last_d       <= 1'b0;
         wd           <= 1'b0;
         bus.ihit     <= 1'b0;
         bus.dhit     <= 1'b0;
         bus.iload    <= '0;
         bus.dload    <= '0;
         bus.ramREN   <= 1'b0;
         bus.ramWEN   <= 1'b0;
         bus.ramaddr  <= '0;
         bus.ramstore <= '0;
         bus.err      <= 1'b0;
      end else begin
         bus.ihit <= 1'b0;
         bus.dhit <= 1'b0;
         case (state)
            IDLE, RESP: begin
               wait_cnt <= '0;
               wd       <= 1'b0;
               if (next_state == DACC) begin
                  bus.ramREN   <= bus.dREN && !bus.dWEN;
                  bus.ramWEN   <= bus.dWEN;
                  bus.ramaddr  <= bus.daddr;
                  bus.ramstore <= bus.dstore;
               end else if (next_state == IACC) begin
                  bus.ramREN   <= 1'b1;
                  bus.ramWEN   <= 1'b0;
                  bus.ramaddr  <= bus.iaddr;
                  bus.ramstore <= '0;
               end
            end
            IACC, DACC: begin
               if (done) begin
                  bus.ramREN   <= 1'b0;
                  bus.ramWEN   <= 1'b0;
                  bus.ramaddr  <= '0;
                  bus.ramstore <= '0;
                  last_d       <= (state == DACC);
                  if (timeout) bus.err <= 1'b1;
                  if (!abort) begin
                     if (state == DACC) begin
                        bus.dhit <= 1'b1;
                        if (bus.ramREN) bus.dload <= timeout ? ERR_WORD : bus.ramload;
                     end else begin
                        bus.ihit  <= 1'b1;
                        bus.iload <= timeout ? ERR_WORD : bus.ramload;
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
                  wd       <= abort;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level reference model.
module tb_mem_arbiter;
   localparam int unsigned TMO  = 8;
   localparam logic [31:0] ERRW = 32'hBAD1BAD1;

   logic CLK = 1'b0;
   logic nRST;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT(TMO), .ERR_WORD(ERRW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   typedef logic [132:0] ovec_t;

   function automatic ovec_t pack(input logic rren, rwen, ih, dh, er,
                                  input logic [31:0] ra, rs, il, dl);
      return {rren, rwen, ih, dh, er, ra, rs, il, dl};
   endfunction

   function automatic ovec_t dut_out();
      return pack(bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err,
                  bus.ramaddr, bus.ramstore, bus.iload, bus.dload);
   endfunction

   task automatic check(input string name, input ovec_t act, input ovec_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic iren, input logic [31:0] iaddr,
                        input logic dren, dwen, input logic [31:0] daddr, dstore,
                        input logic rdy, input logic [31:0] rload);
      bus.iREN     = iren;
      bus.iaddr    = iaddr;
      bus.dREN     = dren;
      bus.dWEN     = dwen;
      bus.daddr    = daddr;
      bus.dstore   = dstore;
      bus.ramready = rdy;
      bus.ramload  = rload;
   endtask

   typedef struct {
      string       name;
      logic        iren, dren, dwen, rdy;
      logic [31:0] iaddr, daddr, dstore, rload;
      ovec_t       exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string n, input logic iren, input logic [31:0] iaddr,
                               input logic dren, dwen, input logic [31:0] daddr, dstore,
                               input logic rdy, input logic [31:0] rload, input ovec_t exp);
      vec_t v;
      v.name = n;   v.iren = iren;     v.iaddr = iaddr; v.dren = dren; v.dwen = dwen;
      v.daddr = daddr; v.dstore = dstore; v.rdy = rdy; v.rload = rload; v.exp = exp;
      return v;
   endfunction

   // Reference model: one in-flight transaction record plus the response registers
   logic        m_busy, m_is_d, m_rd, m_wr, m_wd, m_last_d;
   logic [31:0] m_addr, m_store, m_iload, m_dload;
   logic        m_ihit, m_dhit, m_err;
   int          m_age;

   task automatic model_reset();
      m_busy = 0; m_is_d = 0; m_rd = 0; m_wr = 0; m_wd = 0; m_last_d = 0;
      m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
      m_ihit = 0; m_dhit = 0; m_err = 0; m_age = 0;
   endtask

   function automatic ovec_t model_out();
      return pack(m_busy && (!m_is_d || m_rd), m_busy && m_is_d && m_wr, m_ihit, m_dhit, m_err,
                  m_busy ? m_addr : 32'h0, (m_busy && m_is_d) ? m_store : 32'h0, m_iload, m_dload);
   endfunction

   task automatic model_step();
      logic wd_now, tmo;
      m_ihit = 0;
      m_dhit = 0;
      if (m_busy) begin
         wd_now = m_wd || (m_is_d ? !(bus.dREN || bus.dWEN) : !bus.iREN);
         tmo    = !bus.ramready && (m_age == int'(TMO) - 1);
         if (bus.ramready || tmo) begin
            m_busy   = 0;
            m_last_d = m_is_d;
            if (tmo) m_err = 1;
            if (!wd_now) begin
               if (m_is_d) begin
                  m_dhit = 1;
                  if (m_rd) m_dload = tmo ? ERRW : bus.ramload;
               end else begin
                  m_ihit  = 1;
                  m_iload = tmo ? ERRW : bus.ramload;
               end
            end
         end else begin
            m_age++;
            m_wd = wd_now;
         end
      end else if ((bus.dREN || bus.dWEN) && !(bus.iREN && m_last_d)) begin
         m_busy = 1; m_is_d = 1; m_age = 0; m_wd = 0;
         m_wr = bus.dWEN; m_rd = bus.dREN && !bus.dWEN;
         m_addr = bus.daddr; m_store = bus.dstore;
      end else if (bus.iREN) begin
         m_busy = 1; m_is_d = 0; m_age = 0; m_wd = 0;
         m_wr = 0; m_rd = 0; m_addr = bus.iaddr; m_store = '0;
      end
   endtask

   int strobe_cycles;
   int got_hit;

   initial begin
      // fetch with a 3-cycle RAM, then iaddr changes mid-access that must be ignored
      tbl.push_back(mk("fetch_req",  1, 32'h40, 0,0, 0,0, 0, 0,            pack(1,0,0,0,0, 32'h40,0, 0,0)));
      tbl.push_back(mk("fetch_w1",   1, 32'h48, 0,0, 0,0, 0, 0,            pack(1,0,0,0,0, 32'h40,0, 0,0)));
      tbl.push_back(mk("fetch_w2",   1, 32'h48, 0,0, 0,0, 0, 0,            pack(1,0,0,0,0, 32'h40,0, 0,0)));
      tbl.push_back(mk("fetch_rdy",  1, 32'h40, 0,0, 0,0, 1, 32'h8C220004, pack(0,0,1,0,0, 0,0, 32'h8C220004,0)));
      tbl.push_back(mk("fetch_idle", 0, 0,      0,0, 0,0, 0, 0,            pack(0,0,0,0,0, 0,0, 32'h8C220004,0)));
      // simultaneous fetch + data read, last_d=0: data first
      tbl.push_back(mk("simul_req",  1, 32'h44, 1,0, 32'h100,32'h11111111, 0, 0, pack(1,0,0,0,0, 32'h100,32'h11111111, 32'h8C220004,0)));
      tbl.push_back(mk("simul_drdy", 1, 32'h44, 1,0, 32'h100,32'h11111111, 1, 32'hCAFE0001, pack(0,0,0,1,0, 0,0, 32'h8C220004,32'hCAFE0001)));
      tbl.push_back(mk("simul_ireq", 1, 32'h44, 0,0, 0,0, 0, 0,            pack(1,0,0,0,0, 32'h44,0, 32'h8C220004,32'hCAFE0001)));
      tbl.push_back(mk("simul_irdy", 1, 32'h44, 0,0, 0,0, 1, 32'h12345678, pack(0,0,1,0,0, 0,0, 32'h12345678,32'hCAFE0001)));
      tbl.push_back(mk("simul_idle", 0, 0,      0,0, 0,0, 0, 0,            pack(0,0,0,0,0, 0,0, 32'h12345678,32'hCAFE0001)));
      // fairness: fetch and write held, RAM ready every cycle
      for (int unsigned r = 0; r < 2; r++) begin
         tbl.push_back(mk("fair_d",    1, 32'h80, 0,1, 32'h300,32'hDEADBEEF, 1, 32'h0BADF00D,
                          pack(0,1,0,0,0, 32'h300,32'hDEADBEEF, (r == 0) ? 32'h12345678 : 32'h0BADF00D, 32'hCAFE0001)));
         tbl.push_back(mk("fair_dhit", 1, 32'h80, 0,1, 32'h300,32'hDEADBEEF, 1, 32'h0BADF00D,
                          pack(0,0,0,1,0, 0,0, (r == 0) ? 32'h12345678 : 32'h0BADF00D, 32'hCAFE0001)));
         tbl.push_back(mk("fair_i",    1, 32'h80, 0,1, 32'h300,32'hDEADBEEF, 1, 32'h0BADF00D,
                          pack(1,0,0,0,0, 32'h80,0, (r == 0) ? 32'h12345678 : 32'h0BADF00D, 32'hCAFE0001)));
         tbl.push_back(mk("fair_ihit", 1, 32'h80, 0,1, 32'h300,32'hDEADBEEF, 1, 32'h0BADF00D,
                          pack(0,0,1,0,0, 0,0, 32'h0BADF00D, 32'hCAFE0001)));
      end
      tbl.push_back(mk("fair_idle",   0, 0, 0,0, 0,0, 0, 0, pack(0,0,0,0,0, 0,0, 32'h0BADF00D,32'hCAFE0001)));
      // read+write together is a write; dload untouched
      tbl.push_back(mk("wr_conf_req", 0, 0, 1,1, 32'h200,32'h55AA55AA, 0, 0, pack(0,1,0,0,0, 32'h200,32'h55AA55AA, 32'h0BADF00D,32'hCAFE0001)));
      tbl.push_back(mk("wr_conf_rdy", 0, 0, 1,1, 32'h200,32'h55AA55AA, 1, 32'hFFFFFFFF, pack(0,0,0,1,0, 0,0, 32'h0BADF00D,32'hCAFE0001)));
      tbl.push_back(mk("wr_conf_idle",0, 0, 0,0, 0,0, 0, 0, pack(0,0,0,0,0, 0,0, 32'h0BADF00D,32'hCAFE0001)));

      nRST = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge CLK);
      check("reset_state", dut_out(), '0);
      nRST = 1'b1;

      foreach (tbl[k]) begin
         drive(tbl[k].iren, tbl[k].iaddr, tbl[k].dren, tbl[k].dwen,
               tbl[k].daddr, tbl[k].dstore, tbl[k].rdy, tbl[k].rload);
         @(negedge CLK);
         check(tbl[k].name, dut_out(), tbl[k].exp);
      end

      // fetch withdrawn before ramready: access completes, no hit, iload kept
      drive(1, 32'h500, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      check("abort_strobe", dut_out(), pack(1,0,0,0,0, 32'h500,0, 32'h0BADF00D,32'hCAFE0001));
      bus.iREN = 0;
      @(negedge CLK);
      bus.ramready = 1; bus.ramload = 32'h77777777;
      @(negedge CLK);
      check("abort_nohit", dut_out(), pack(0,0,0,0,0, 0,0, 32'h0BADF00D,32'hCAFE0001));
      bus.ramready = 0;
      @(negedge CLK);
      check("abort_after", dut_out(), pack(0,0,0,0,0, 0,0, 32'h0BADF00D,32'hCAFE0001));

      // RAM never answers: watchdog completes the read with the error word
      drive(0, 0, 1, 0, 32'h400, 0, 0, 32'h5A5A5A5A);
      strobe_cycles = 0;
      got_hit = 0;
      for (int c = 0; c < 30 && got_hit == 0; c++) begin
         @(negedge CLK);
         if (bus.ramREN) strobe_cycles++;
         if (bus.dhit) begin
            got_hit = 1;
            check("tmo_hit", dut_out(), pack(0,0,0,1,1, 0,0, 32'h0BADF00D, ERRW));
            bus.dREN = 0;
         end
      end
      check32("tmo_seen", got_hit, 1);
      check32("tmo_strobes", strobe_cycles, TMO);
      repeat (3) @(negedge CLK);
      check("tmo_err_sticky", dut_out(), pack(0,0,0,0,1, 0,0, 32'h0BADF00D, ERRW));

      // asynchronous reset in the middle of a data access
      drive(0, 0, 1, 0, 32'h600, 32'h1, 0, 0);
      repeat (2) @(negedge CLK);
      #2 nRST = 1'b0;
      #1 check("reset_async", dut_out(), '0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      nRST = 1'b1;
      drive(1, 32'h700, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      check("post_rst_strobe", dut_out(), pack(1,0,0,0,0, 32'h700,0, 0,0));
      bus.ramready = 1; bus.ramload = 32'h13572468;
      @(negedge CLK);
      check("post_rst_hit", dut_out(), pack(0,0,1,0,0, 0,0, 32'h13572468,0));
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // random traffic against the reference model
      @(negedge CLK);
      nRST = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      model_reset();
      for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
         check("random", dut_out(), model_out());
         if (m_ihit)                         bus.iREN = ($urandom_range(0, 3) == 0);
         else if (!bus.iREN)                 bus.iREN = ($urandom_range(0, 2) == 0);
         else if ($urandom_range(0, 40) == 0) bus.iREN = 1'b0;
         if (m_dhit || !(bus.dREN || bus.dWEN)) begin
            if ($urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 2))
                  0:       begin bus.dREN = 1; bus.dWEN = 0; end
                  1:       begin bus.dREN = 0; bus.dWEN = 1; end
                  default: begin bus.dREN = 1; bus.dWEN = 1; end
               endcase
            end else begin
               bus.dREN = 0; bus.dWEN = 0;
            end
         end else if ($urandom_range(0, 40) == 0) begin
            bus.dREN = 0; bus.dWEN = 0;
         end
         bus.iaddr    = $urandom;
         bus.daddr    = $urandom;
         bus.dstore   = $urandom;
         bus.ramload  = $urandom;
         bus.ramready = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         model_step();
         @(negedge CLK);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder for the pipeline's memory-request interface.
- Accepts instruction fetches (iREN) and data reads/writes (dREN/dWEN) from the datapath and serialises them onto a single RAM port.
- Returns one-cycle ihit/dhit pulses with load data; these are the hit signals the hazard unit consumes to stall or advance the pipeline.
- Data requests take priority. A fairness flag prevents instruction starvation. A watchdog bounds RAM stalls.

Parameters:
- TIMEOUT, 64, max cycles waiting for ramready before the access is force-completed.
- ERR_WORD, 32'hBAD1BAD1, load value returned on a timed-out read.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- iREN  input  1  instruction read request, level, held until ihit
- iaddr  input  32  instruction address, stable while iREN
- ihit  output  1  one-cycle pulse: iload valid
- iload  output  32  instruction word, valid while ihit
- dREN  input  1  data read request, level, held until dhit
- dWEN  input  1  data write request, level, held until dhit
- daddr  input  32  data address
- dstore  input  32  write data
- dhit  output  1  one-cycle pulse: data access complete, dload valid for reads
- dload  output  32  read data, valid while dhit
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data, valid in the ramready cycle
- ramready  input  1  RAM completion, single cycle
- err  output  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset: state=IDLE, last_d=0, wait counter=0.
  - All outputs 0: ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err.
- FSM states: IDLE, IACC, DACC, RESP.
- Arbitration (evaluated in IDLE and RESP):
  - If (dREN|dWEN) and !(iREN && last_d): go to DACC.
  - Else if iREN: go to IACC.
  - Else: go to IDLE.
  - Data wins unless the previous completed access was data and an instruction is pending.
  - last_d is updated when an access enters RESP.
- Latching on entry to IACC/DACC:
  - Latch address, store data and op type.
  - Later input changes are ignored until the access completes.
- IACC: ramREN=1, ramaddr=latched iaddr.
- DACC:
  - ramREN=dREN_latched, ramWEN=dWEN_latched.
  - If both dREN and dWEN were high at capture, the access is a write (ramREN=0).
  - ramaddr=latched daddr, ramstore=latched dstore.
- RAM strobes and address are registered and held stable until the cycle ramready=1.
  - They drop to 0 the cycle after.
- On ramready in IACC/DACC:
  - Register ramload into iload/dload.
  - Go to RESP. In RESP, the matching hit is 1 for exactly one cycle.
- Minimum latency: request seen in IDLE at cycle N, strobe at N+1, ramready at N+1, hit at N+2.
- Back-to-back: RESP arbitrates directly into the next access, with no IDLE bubble.
- ihit and dhit are never 1 in the same cycle.
- Load data holds its value after the hit, until the next corresponding response.
- Writes:
  - dload is not updated.
  - dhit still pulses.
- Request withdrawn mid-access (requester deasserts iREN/dREN/dWEN before ramready):
  - The RAM access completes normally.
  - The hit pulse is suppressed.
  - Load registers are not updated.
- Watchdog:
  - Counter increments each cycle in IACC/DACC without ramready.
  - When the counter reaches TIMEOUT-1 without ramready, the access is abandoned that cycle: strobes drop and err is set.
  - The response is delivered as normal: ERR_WORD for reads; writes are dropped.
  - Counter clears on every entry to IACC/DACC.
- Reset asserted mid-access:
  - All state and outputs return to reset values immediately.
  - An in-flight RAM access is abandoned.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40, RAM ready after 3 cycles with 0x8C220004 → ramREN held 3 cycles, ramaddr=0x40; ihit pulses 1 cycle with iload=0x8C220004; dhit stays 0.
- Simultaneous request: iREN=1 and dREN=1 (daddr=0x100) in the same cycle, last_d=0 → data served first (ramaddr=0x100, dhit); instruction served next (ihit); ihit and dhit never coincide.
- Fairness: iREN and dWEN both held continuously, RAM ready every cycle → accesses alternate D,I,D,I; write data 0xDEADBEEF appears on ramstore during each data access.
- Write+read conflict: dREN=dWEN=1 → ramWEN=1, ramREN=0; dhit pulses; dload unchanged from its prior value.
- Timeout: TIMEOUT=8, dREN=1, ramready never asserted → strobes drop after 8 cycles; dhit pulses with dload=0xBAD1BAD1; err=1 and stays 1 until nRST.
- Abort and reset: iREN dropped before ramready → no ihit, iload unchanged. Separately, nRST pulsed during DACC → all outputs 0 asynchronously; a fetch after reset completes normally.
